// File: rtl/shiftreg_rx.sv
// shiftreg_rx: serial-to-parallel receiver (MSB first) with a valid/ready output
// register and a sticky framing/overrun error flag.
(* tamara_triplicate *)
module shiftreg_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din_valid,
  input  logic             din,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  (* tamara_error_sink *)
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    cnt, cntNext;
  logic [WIDTH-1:0] shreg, shregNext, word;
  logic             wordDone, restart, transfer, load, overrun;

  // Frame tracking: only accepted bits (din_valid) move the shifter, counter or state.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    shregNext = shreg;
    wordDone  = 1'b0;
    restart   = 1'b0;
    word      = {shreg[WIDTH-2:0], din};
    if (din_valid) begin
      case (state)
        IDLE: begin
          if (start) begin
            shregNext = word;
            cntNext   = CW'(1);
            stateNext = SHIFT;
          end
        end
        SHIFT: begin
          shregNext = word;
          if (start) begin
            cntNext = CW'(1);
            restart = 1'b1;
          end else if (cnt == CW'(WIDTH - 1)) begin
            cntNext   = '0;
            stateNext = IDLE;
            wordDone  = 1'b1;
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // A completed word is only accepted when the output slot is free or emptying this cycle.
  always_comb begin
    transfer = dout_valid && out_ready;
    load     = wordDone && (!dout_valid || out_ready);
    overrun  = wordDone && dout_valid && !out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      shreg <= shregNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (transfer) begin
        dout_valid <= 1'b0;
      end
      // A fresh error wins over a simultaneous clear.
      if (restart || overrun) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_rx.sv
// Self-checking bench for shiftreg_rx: directed frames with literal expectations,
// then randomized traffic compared every cycle against a queue-based frame model.
module tb_shiftreg_rx;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             out_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             err;

  int totalChecks = 0;
  int passedChecks = 0;
  bit compareEn = 1'b0;

  shiftreg_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din(din),
    .out_ready(out_ready), .err_clr(err_clr),
    .dout(dout), .dout_valid(dout_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: collect frame bits in a queue, build the word arithmetically once full.
  int               frameBits[$];
  bit               inFrame;
  logic [WIDTH-1:0] mDout;
  bit               mDv, mErr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frameBits = {};
      inFrame = 0;
      mDout = '0;
      mDv = 0;
      mErr = 0;
    end else begin
      bit done, setErr;
      int w;
      done = 0;
      setErr = 0;
      w = 0;
      if (din_valid) begin
        if (start) begin
          if (inFrame) setErr = 1;
          frameBits = {};
          frameBits.push_back(int'(din));
          inFrame = 1;
        end else if (inFrame) begin
          frameBits.push_back(int'(din));
        end
        if (inFrame && frameBits.size() == WIDTH) begin
          foreach (frameBits[i]) w = w * 2 + frameBits[i];
          done = 1;
          inFrame = 0;
          frameBits = {};
        end
      end
      if (done) begin
        if (!mDv || out_ready) begin
          mDout = WIDTH'(w);
          mDv = 1;
        end else begin
          setErr = 1;
        end
      end else if (mDv && out_ready) begin
        mDv = 0;
      end
      if (setErr) mErr = 1;
      else if (err_clr) mErr = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (compareEn) begin
      check("model dout", 32'(dout), 32'(mDout));
      check("model dout_valid", 32'(dout_valid), 32'(mDv));
      check("model err", 32'(err), 32'(mErr));
    end
  end

  task automatic applyStimulus(input logic s, input logic v, input logic d,
                               input logic r, input logic c);
    start = s;
    din_valid = v;
    din = d;
    out_ready = r;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expDout,
                             input logic expDv, input logic expErr);
    check({name, " dout"}, 32'(dout), 32'(expDout));
    check({name, " dout_valid"}, 32'(dout_valid), 32'(expDv));
    check({name, " err"}, 32'(err), 32'(expErr));
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w, input logic r);
    for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(i == WIDTH - 1, 1'b1, w[i], r, 1'b0);
  endtask

  initial begin
    #3;
    checkOutput("reset", 4'h0, 1'b0, 1'b0);
    #9 rst = 1'b1;
    compareEn = 1'b1;
    applyStimulus(0, 0, 0, 1, 0);

    // Basic frame 1011, valid one cycle after the final bit edge
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("frame1011 pre", 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("frame1011", 4'b1011, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("frame1011 consumed", 4'b1011, 1'b0, 1'b0);

    // Gaps in din_valid between bits 2 and 3
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("gapped frame", 4'b1011, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 1, 0);

    // Restart mid-frame sets err, sticky until cleared
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    sendFrame(4'b0101, 1'b1);
    checkOutput("restart", 4'b0101, 1'b1, 1'b1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("err sticky", 4'b0101, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("err cleared", 4'b0101, 1'b0, 1'b0);

    // Overrun: second word dropped while first not consumed
    sendFrame(4'hA, 1'b0);
    sendFrame(4'h5, 1'b0);
    checkOutput("overrun", 4'hA, 1'b1, 1'b1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("overrun drained", 4'hA, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 0, 1);

    // Back-to-back frames
    sendFrame(4'h3, 1'b1);
    checkOutput("b2b first", 4'h3, 1'b1, 1'b0);
    sendFrame(4'hC, 1'b1);
    checkOutput("b2b second", 4'hC, 1'b1, 1'b0);

    // Asynchronous reset mid-frame, then a frame without start is ignored
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1 checkOutput("async reset", 4'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    sendFrame(4'h9, 1'b1);
    checkOutput("post-reset frame", 4'h9, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0);

    compareEn = 1'b0;
    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/shiftreg_rx.md
SHIFTREG_RX -- requirements
Module: shiftreg_rx

Interface
REQ-001 Parameter: WIDTH, default 4, frame length in bits and output word width; legal range 2..32.
REQ-002 Module SHALL carry the (* tamara_triplicate *) attribute.
REQ-003 clk  input  1  sole clock, all state on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  frame start; qualifies the din bit in the same cycle as frame bit 0.
REQ-006 din_valid  input  1  din carries a valid bit this cycle.
REQ-007 din  input  1  serial data, MSB first.
REQ-008 out_ready  input  1  consumer accepts dout this cycle.
REQ-009 err_clr  input  1  clears the sticky err flag.
REQ-010 dout  output  WIDTH  last completed parallel word.
REQ-011 dout_valid  output  1  dout holds an unconsumed word.
REQ-012 err  output  1  sticky framing/overrun flag; port SHALL carry the (* tamara_error_sink *) attribute.

Function
REQ-013 FSM states SHALL be IDLE and SHIFT; a bit counter of width clog2(WIDTH+1) SHALL track the received bit count.
REQ-014 Bit accepted = din_valid high at posedge; cycles with din_valid low SHALL leave shift register, counter and state unchanged.
REQ-015 IDLE: din_valid && start -> shift in din, count=1, go SHIFT; din_valid without start -> bit ignored, stay IDLE.
REQ-016 Shift SHALL be MSB first: shreg <= {shreg[WIDTH-2:0], din}; first bit of a frame SHALL end in dout[WIDTH-1].
REQ-017 SHIFT: an accepted bit without start SHALL be shifted in and the count incremented.
REQ-018 On the WIDTH-th accepted bit, the completed word ({shreg[WIDTH-2:0], din}) SHALL be offered to the output register on that same edge, count cleared, state -> IDLE; dout_valid high the cycle after the final bit edge (latency 1 clock from last bit).
REQ-019 start && din_valid in SHIFT (frame restart) SHALL discard the partial frame, begin a new frame with that bit (count=1, stay SHIFT), and set err.
REQ-020 start without din_valid SHALL have no effect in any state.
REQ-021 Output handshake: word transfer occurs when dout_valid && out_ready; dout_valid SHALL stay high and dout stable until transfer.
REQ-022 Word completes with no unconsumed word, or with transfer in the same cycle: dout <= new word, dout_valid <= 1.
REQ-023 Word completes while dout_valid && !out_ready (overrun): new word SHALL be dropped, dout unchanged, err set.
REQ-024 Transfer with no word completing: dout_valid <= 0; dout SHALL retain its value.
REQ-025 err SHALL be sticky; err_clr clears it; a new error in the same cycle as err_clr SHALL leave err set.
REQ-026 Back-to-back frames (start on the cycle after final bit) SHALL be received with no lost bit.

Reset
REQ-027 rst low SHALL immediately, without clk, force state IDLE, counter 0, shift register 0, dout 0, dout_valid 0, err 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; after rst rises, the next frame SHALL require start.
REQ-029 Outputs SHALL be driven only from registers (no combinational input-to-output paths).

Verification (WIDTH=4)
REQ-030 Frame bits 1,0,1,1 on consecutive cycles, start with first, out_ready=1 -> dout=4'b1011, dout_valid high exactly one cycle after 4th bit edge, err=0.
REQ-031 Same frame with din_valid low for 2 cycles between bits 2 and 3 -> dout=4'b1011, dout_valid one cycle after the last valid bit.
REQ-032 Bits 1,1 then start with bits 0,1,0,1 -> dout=4'b0101, err=1 and stays 1 until err_clr pulse, then 0.
REQ-033 out_ready=0, frames 4'hA then 4'h5 -> dout stays 4'hA, dout_valid=1, err=1; out_ready=1 one cycle -> dout_valid=0.
REQ-034 Two back-to-back frames 4'h3, 4'hC with out_ready=1 -> dout=4'h3 then 4'hC on consecutive completions, err=0.
REQ-035 rst low after 2 bits (asynchronous, between edges) -> all outputs 0 immediately; subsequent full frame 4'h9 -> dout=4'h9.
